// File: rtl/adder_sched_pkg.sv
// Shared types and constants for the adder scheduler.
// Operands are Q8.8, sums come back from the adder as Q9.7.
package adder_sched_pkg;

    localparam int DATA_W   = 16;
    localparam int FRAC_IN  = 8;
    localparam int FRAC_OUT = 7;
    localparam int CNT_W    = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_RESP = 2'd2
    } state_e;

endpackage

// File: rtl/adder_scheduler_rr_arbiter.sv
// Request arbiter for the adder scheduler: round-robin by default,
// fixed lowest-index priority when ADDER_SCHED_FIXED_PRIO_EN is defined.
module rr_arbiter #(
    parameter int N_REQ = 4,
    parameter int ID_W  = $clog2(N_REQ)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_REQ-1:0] req,
    input  logic             accept,
    output logic [N_REQ-1:0] grant,
    output logic [ID_W-1:0]  grant_id,
    output logic             grant_any
);

`ifdef ADDER_SCHED_FIXED_PRIO_EN

    logic unused_ok;
    assign unused_ok = ^{clk, rst_n, accept};

    always_comb begin
        grant_id  = '0;
        grant_any = 1'b0;
        for (int k = 0; k < N_REQ; k++) begin
            if (!grant_any && req[k]) begin
                grant_any = 1'b1;
                grant_id  = ID_W'(k);
            end
        end
    end

`else

    logic [ID_W-1:0] ptr_q;
    logic [ID_W-1:0] ptr_d;
    int              idx;

    // Search starts at the pointer and wraps around the requester ring.
    always_comb begin
        grant_id  = '0;
        grant_any = 1'b0;
        idx       = 0;
        for (int k = 0; k < N_REQ; k++) begin
            idx = (int'(ptr_q) + k) % N_REQ;
            if (!grant_any && req[idx]) begin
                grant_any = 1'b1;
                grant_id  = ID_W'(idx);
            end
        end
    end

    always_comb begin
        ptr_d = ptr_q;
        if (accept && grant_any) begin
            ptr_d = (int'(grant_id) == N_REQ - 1) ? '0 : grant_id + ID_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

`endif

    assign grant = grant_any ? (N_REQ'(1) << grant_id) : '0;

endmodule

// File: rtl/adder_scheduler.sv
// Time-shares one external fixed-point adder between N_REQ requesters.
// Arbitration policy selected by ADDER_SCHED_FIXED_PRIO_EN (see rr_arbiter).
//
// state   | meaning
// IDLE    | waiting for a request, arbiter grant visible on req_ready
// RUN     | adder enabled with latched operands, latency counter running
// RESP    | sum held on the response port until rsp_ready
module adder_scheduler
    import adder_sched_pkg::*;
#(
    parameter  int N_REQ         = 4,
    parameter  int ADDER_LATENCY = 2,
    localparam int ID_W          = $clog2(N_REQ)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [N_REQ-1:0]      req_valid,
    output logic [N_REQ-1:0]      req_ready,
    input  logic [16*N_REQ-1:0]   req_a,
    input  logic [16*N_REQ-1:0]   req_b,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [ID_W-1:0]       rsp_id,
    output logic [DATA_W-1:0]     rsp_sum,
    output logic                  adder_en,
    output logic [DATA_W-1:0]     adder_a,
    output logic [DATA_W-1:0]     adder_b,
    input  logic [DATA_W-1:0]     adder_sum,
    output logic                  busy
);

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [ID_W-1:0]   id_q, id_d;
    logic [DATA_W-1:0] a_q, a_d, b_q, b_d, sum_q, sum_d;
    logic              en_q, en_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic              busy_q, busy_d;

    logic [N_REQ-1:0]  grant;
    logic [ID_W-1:0]   grant_id;
    logic              grant_any;
    logic              accept;

    assign accept = (state_q == ST_IDLE) && grant_any;

    rr_arbiter #(
        .N_REQ (N_REQ),
        .ID_W  (ID_W)
    ) u_arb (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req_valid),
        .accept    (accept),
        .grant     (grant),
        .grant_id  (grant_id),
        .grant_any (grant_any)
    );

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        id_d        = id_q;
        a_d         = a_q;
        b_d         = b_q;
        sum_d       = sum_q;
        en_d        = en_q;
        rsp_valid_d = rsp_valid_q;
        busy_d      = busy_q;
        case (state_q)
            ST_IDLE: begin
                if (grant_any) begin
                    state_d = ST_RUN;
                    id_d    = grant_id;
                    a_d     = req_a[int'(grant_id)*DATA_W +: DATA_W];
                    b_d     = req_b[int'(grant_id)*DATA_W +: DATA_W];
                    cnt_d   = CNT_W'(ADDER_LATENCY - 1);
                    en_d    = 1'b1;
                    busy_d  = 1'b1;
                end
            end
            ST_RUN: begin
                // Terminal count: adder output is valid on this edge.
                if (cnt_q == '0) begin
                    state_d     = ST_RESP;
                    sum_d       = adder_sum;
                    en_d        = 1'b0;
                    rsp_valid_d = 1'b1;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    state_d     = ST_IDLE;
                    rsp_valid_d = 1'b0;
                    busy_d      = 1'b0;
                end
            end
            default: begin
                state_d     = ST_IDLE;
                en_d        = 1'b0;
                rsp_valid_d = 1'b0;
                busy_d      = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            id_q        <= '0;
            a_q         <= '0;
            b_q         <= '0;
            sum_q       <= '0;
            en_q        <= 1'b0;
            rsp_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            id_q        <= id_d;
            a_q         <= a_d;
            b_q         <= b_d;
            sum_q       <= sum_d;
            en_q        <= en_d;
            rsp_valid_q <= rsp_valid_d;
            busy_q      <= busy_d;
        end
    end

    assign req_ready = ((state_q == ST_IDLE) && rst_n) ? grant : '0;
    assign rsp_valid = rsp_valid_q;
    assign rsp_id    = id_q;
    assign rsp_sum   = sum_q;
    assign adder_en  = en_q;
    assign adder_a   = a_q;
    assign adder_b   = b_q;
    assign busy      = busy_q;

endmodule

// File: doc/adder_scheduler.md
# adder_scheduler

Time-shares one `fixed_point_adder` (16-bit Q8.8 inputs, 16-bit Q9.7 sign-extended sum) between `N_REQ` requesters. Each requester presents an operand pair with a valid/ready handshake. The scheduler arbitrates, drives the adder's enable and operands for the adder's fixed latency, then returns the sum with the requester's ID on a shared response port. It sits between the spectral-processing stages and the single adder instance, so the adder is never duplicated.

## Interface
- `N_REQ`, 4: number of requesters, range 2..8.
- `ADDER_LATENCY`, 2: cycles `adder_en` is held before `adder_sum` is valid, range 1..15.
- `ID_W`: localparam, `$clog2(N_REQ)`.

- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  reset, synchronous, active-low.
- `req_valid`  in  N_REQ  per-requester operand valid.
- `req_ready`  out  N_REQ  per-requester accept, one-hot or zero.
- `req_a`  in  16*N_REQ  flattened Q8.8 operand A; requester i at `[16*i+15:16*i]`.
- `req_b`  in  16*N_REQ  flattened Q8.8 operand B.
- `rsp_valid`  out  1  response valid.
- `rsp_ready`  in  1  response consumer ready.
- `rsp_id`  out  ID_W  index of the requester that owns the response.
- `rsp_sum`  out  16  Q9.7 sum.
- `adder_en`  out  1  adder enable.
- `adder_a`, `adder_b`  out  16  adder operands.
- `adder_sum`  in  16  adder result.
- `busy`  out  1  high whenever state is not IDLE.

## Operation
- States:
  - IDLE: if any `req_valid`, the arbiter selects grant g, `req_ready[g]`=1 combinationally, `req_a`/`req_b`[g] and g are latched at the clock edge, next state RUN. Otherwise stays in IDLE.
  - RUN: `adder_en`=1 and `adder_a`/`adder_b` hold the latched operands. A down-counter loads `ADDER_LATENCY`-1 on entry. When the counter reaches 0, `adder_sum` is captured into `rsp_sum`, and next state is RESP.
  - RESP: `rsp_valid`=1 and `rsp_id`=g. When `rsp_valid && rsp_ready`, next state is IDLE.
- Arbitration is round-robin by default. The priority pointer resets to 0 and moves to g+1 (mod `N_REQ`) on each accept. Search order is pointer, pointer+1, and so on.
- `req_ready` is 0 in every state except IDLE. A requester that drops `req_valid` before being granted loses nothing.
- Arithmetic is performed entirely by the adder. The scheduler does not modify sum bits. `rsp_sum` is Q9.7, with LSB = 2^-7.
- `adder_a`/`adder_b` hold their last value outside RUN and are 0 after reset.

## Timing
- Reset values:
  - state IDLE, pointer 0, counter 0.
  - `req_ready`=0, `rsp_valid`=0, `rsp_id`=0, `rsp_sum`=0.
  - `adder_en`=0, `adder_a`=`adder_b`=0, `busy`=0.
- Accept edge E0 → `adder_en` high for exactly `ADDER_LATENCY` cycles → `rsp_valid` high from edge E0+`ADDER_LATENCY`.
- Minimum issue interval, with `rsp_ready` tied high, is `ADDER_LATENCY`+2 cycles (IDLE, RUN×LAT, RESP).
- `rsp_valid`/`rsp_id`/`rsp_sum` are stable while `rsp_ready`=0. A response is never overwritten.
- Simultaneous valids are resolved in a single cycle by the arbiter. Only one `req_ready` bit is ever high.
- If `rst_n`=0 in any state, the next edge forces all reset values. An in-flight operation is discarded without a response, and `adder_en` drops on that edge.

## Configuration
- `ADDER_SCHED_FIXED_PRIO_EN`:
  - Defined: fixed priority, lowest index wins, pointer logic removed.
  - Undefined: round-robin as above.
- Port list and timing are identical in both cases.

## Structure
- Package `adder_sched_pkg` contains:
  - state enum (IDLE, RUN, RESP).
  - `DATA_W`=16, `FRAC_IN`=8, `FRAC_OUT`=7.
  - latency counter width (4).
- Sub-module `rr_arbiter` handles the request vector, pointer and one-hot grant, including the fixed-priority variant under the macro. The adder itself is instantiated outside this block.

## Test plan
- Req0 with A=0x0180 (1.5), B=0x0040 (0.25), `rsp_ready`=1 → `rsp_valid` 2 cycles after accept, `rsp_id`=0, `rsp_sum`=0x00E0 (1.75).
- Req2 with A=0xFF00 (-1.0), B=0xFE80 (-1.5) → `rsp_sum`=0xFEC0 (-2.5), `rsp_id`=2.
- Req1 with A=B=0x7FFF → `rsp_sum`=0x7FFF (extended sum, no wrap).
- All four requesters valid continuously → grants 0,1,2,3,0, each separated by 4 cycles. With `ADDER_SCHED_FIXED_PRIO_EN`, grants are 0,0,0.
- `rsp_ready` held 0 for 5 cycles in RESP → outputs stable, `req_ready` stays 0, no new accept until the handshake completes.
- `rst_n`=0 during the second RUN cycle → next edge: `adder_en`=0, `busy`=0, `rsp_valid` never rises, pointer is 0.
